// File: rtl/led_pattern_seq.sv
// N-LED, M-step pattern sequencer with loop, one-shot and ping-pong modes.
// Each step shows a stored pattern for a programmable number of prescaled ticks.
module led_pattern_seq #(
  parameter int NUM_LEDS  = 4,
  parameter int NUM_STEPS = 4,
  parameter int DUR_W     = 8,
  parameter int PRESCALE  = 16000,
  parameter logic [NUM_STEPS*NUM_LEDS-1:0] PATTERNS =
    {4'h8, 4'h4, 4'h2, 4'h1},
  parameter logic [NUM_STEPS*DUR_W-1:0] DURATIONS =
    {8'd3, 8'd1, 8'd2, 8'd1}
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                STOP,
  input  logic                PAUSE,
  input  logic [1:0]          MODE,
  output logic [NUM_LEDS-1:0] LED,
  output logic [(NUM_STEPS > 1 ? $clog2(NUM_STEPS) : 1)-1:0] STEP_IDX,
  output logic                BUSY,
  output logic                DONE
);

  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] LAST    = SW'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  state_t              state_q;
  logic [1:0]          mode_q;
  logic                dir_q;
  logic [PW-1:0]       pre_q;
  logic [DUR_W-1:0]    dur_q;
  logic [SW-1:0]       step_q;
  logic [NUM_LEDS-1:0] led_q;
  logic                busy_q;
  logic                done_q;

  logic [DUR_W-1:0]    dur_k;
  logic [DUR_W-1:0]    dur_lim;
  logic                tick;
  logic                dur_hit;
  logic                last;
  logic                finish;
  logic                nxt_dir;
  logic [SW-1:0]       nxt_step;
  logic [NUM_LEDS-1:0] nxt_led;

  always_comb begin
    dur_k    = DURATIONS[int'(step_q)*DUR_W +: DUR_W];
    // A zero duration field behaves as one tick
    dur_lim  = (dur_k == '0) ? '0 : dur_k - DUR_W'(1);
    tick     = (pre_q == PRE_MAX);
    dur_hit  = (dur_q == dur_lim);
    last     = (step_q == LAST);
    finish   = 1'b0;
    nxt_dir  = dir_q;
    nxt_step = step_q + SW'(1);
    unique case (mode_q)
      2'd0: begin
        if (last) nxt_step = '0;
      end
      2'd2: begin
        if (!dir_q) begin
          if (last) begin
            nxt_step = step_q - SW'(1);
            nxt_dir  = 1'b1;
          end
        end else if (step_q == '0) begin
          nxt_dir = 1'b0;
        end else begin
          nxt_step = step_q - SW'(1);
        end
      end
      default: finish = last;
    endcase
    nxt_led = PATTERNS[int'(nxt_step)*NUM_LEDS +: NUM_LEDS];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      dir_q   <= 1'b0;
      pre_q   <= '0;
      dur_q   <= '0;
      step_q  <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (STOP) begin
        state_q <= IDLE;
        pre_q   <= '0;
        dur_q   <= '0;
        step_q  <= '0;
        led_q   <= '0;
        busy_q  <= 1'b0;
      end else if (START) begin
        state_q <= RUN;
        mode_q  <= MODE;
        dir_q   <= 1'b0;
        pre_q   <= '0;
        dur_q   <= '0;
        step_q  <= '0;
        led_q   <= PATTERNS[NUM_LEDS-1:0];
        busy_q  <= 1'b1;
      end else if (state_q != IDLE) begin
        // The resume edge counts, so a pause costs exactly its high cycles
        if (PAUSE) begin
          state_q <= PAUSED;
        end else begin
          state_q <= RUN;
          if (!tick) begin
            pre_q <= pre_q + PW'(1);
          end else begin
            pre_q <= '0;
            if (!dur_hit) begin
              dur_q <= dur_q + DUR_W'(1);
            end else begin
              dur_q <= '0;
              if (finish) begin
                state_q <= IDLE;
                step_q  <= '0;
                led_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                step_q <= nxt_step;
                led_q  <= nxt_led;
                dir_q  <= nxt_dir;
              end
            end
          end
        end
      end
    end
  end

  assign LED      = led_q;
  assign STEP_IDX = step_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with PRESCALE=2.
// Step lengths in cycles: 2,4,2,6; patterns 1,2,4,8.
module tb_led_pattern_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       PAUSE = 1'b0;
  logic [1:0] MODE = 2'd0;
  logic [3:0] LED;
  logic [1:0] STEP_IDX;
  logic       BUSY;
  logic       DONE;

  int n_chk = 0;
  int n_err = 0;

  led_pattern_seq #(
    .NUM_LEDS (4),
    .NUM_STEPS(4),
    .DUR_W    (8),
    .PRESCALE (2),
    .PATTERNS ({4'h8, 4'h4, 4'h2, 4'h1}),
    .DURATIONS({8'd3, 8'd1, 8'd2, 8'd1})
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .STOP    (STOP),
    .PAUSE   (PAUSE),
    .MODE    (MODE),
    .LED     (LED),
    .STEP_IDX(STEP_IDX),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic go(input logic [1:0] m);
    START = 1'b1;
    MODE  = m;
    cyc();
    START = 1'b0;
  endtask

  // Loop-mode LED after the i-th edge following the START edge
  function automatic int loop_led(input int i);
    int r;
    r = i % 14;
    if (r < 2) return 1;
    if (r < 6) return 2;
    if (r < 8) return 4;
    return 8;
  endfunction

  int lens [4] = '{2, 4, 2, 6};
  int pp_ord [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int pp_q [$];
  int ip;

  initial begin
    // Reset state
    #12;
    chk("rst_led", LED, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_step", STEP_IDX, 0);
    chk("rst_done", DONE, 0);
    RST = 1'b0;
    cyc();

    // One-shot; MODE changed afterwards must be ignored
    go(2'd1);
    MODE = 2'd0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("os_led%0d", i), LED, (i < 14) ? loop_led(i) : 0);
      chk($sformatf("os_done%0d", i), DONE, (i == 14) ? 1 : 0);
      chk($sformatf("os_busy%0d", i), BUSY, (i < 14) ? 1 : 0);
      cyc();
    end

    // Loop
    go(2'd0);
    for (int i = 0; i < 30; i++) begin
      chk($sformatf("lp_led%0d", i), LED, loop_led(i));
      chk($sformatf("lp_done%0d", i), DONE, 0);
      cyc();
    end

    // Ping-pong
    foreach (pp_ord[k])
      for (int j = 0; j < lens[pp_ord[k]]; j++)
        pp_q.push_back(pp_ord[k]);
    go(2'd2);
    for (int i = 0; i < pp_q.size(); i++) begin
      chk($sformatf("pp_step%0d", i), STEP_IDX, pp_q[i]);
      cyc();
    end

    // Pause for 5 cycles during step 1
    go(2'd0);
    for (int i = 0; i < 24; i++) begin
      ip = (i <= 2) ? i : ((i <= 7) ? 2 : i - 5);
      chk($sformatf("pz_led%0d", i), LED, loop_led(ip));
      chk($sformatf("pz_busy%0d", i), BUSY, 1);
      PAUSE = (i >= 2 && i <= 6);
      cyc();
    end
    PAUSE = 1'b0;

    // START and STOP together: STOP wins
    go(2'd0);
    cyc();
    cyc();
    chk("pr_pre_led", LED, 2);
    START = 1'b1;
    STOP  = 1'b1;
    cyc();
    START = 1'b0;
    STOP  = 1'b0;
    chk("pr_led", LED, 0);
    chk("pr_busy", BUSY, 0);
    chk("pr_step", STEP_IDX, 0);
    cyc();
    chk("pr_idle_led", LED, 0);

    // START alone during step 2 restarts from step 0
    go(2'd0);
    repeat (6) cyc();
    chk("rs_pre_led", LED, 4);
    go(2'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rs_led%0d", i), LED, loop_led(i));
      chk($sformatf("rs_step%0d", i), STEP_IDX, (i < 2) ? 0 : 1);
      cyc();
    end

    // Asynchronous reset mid-cycle
    repeat (5) cyc();
    chk("ar_pre_busy", BUSY, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("ar_led", LED, 0);
    chk("ar_busy", BUSY, 0);
    chk("ar_step", STEP_IDX, 0);
    chk("ar_done", DONE, 0);
    cyc();
    RST = 1'b0;
    cyc();
    chk("ar_idle_led", LED, 0);
    chk("ar_idle_done", DONE, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Parametrised LED pattern sequencer for the TinyFPGA BX (16 MHz CLK). It generalises the single-LED state-machine top into an N-LED, M-step sequencer. Each step drives a stored pattern for a programmable number of prescaled ticks. Supports loop, one-shot and ping-pong modes with start, stop and pause control, and sits between top-level button/debounce logic and the LED pins.

Parameters:
NUM_LEDS, 4, width of LED output bus
NUM_STEPS, 4, number of pattern steps (>=2)
DUR_W, 8, width of each per-step duration field
PRESCALE, 16000, CLK cycles per tick (>=1); 16000 gives a 1 ms tick
PATTERNS, {4'h8,4'h4,4'h2,4'h1}, NUM_STEPS*NUM_LEDS bits; step k at [k*NUM_LEDS +: NUM_LEDS]
DURATIONS, {8'd3,8'd1,8'd2,8'd1}, NUM_STEPS*DUR_W bits; step k at [k*DUR_W +: DUR_W]; value 0 treated as 1

Ports:
CLK  input  1  system clock, 16 MHz
RST  input  1  reset, asynchronous, active-high
START  input  1  single-cycle pulse; starts or restarts the sequence at step 0
STOP  input  1  single-cycle pulse; abort to idle
PAUSE  input  1  level; freezes sequencing while high
MODE  input  2  0=loop, 1=one-shot, 2=ping-pong, 3=one-shot (reserved)
LED  output  NUM_LEDS  current pattern, registered
STEP_IDX  output  clog2(NUM_STEPS)  current step index
BUSY  output  1  high in RUN or PAUSED
DONE  output  1  one-cycle pulse at one-shot completion

Behaviour:
- One clock (CLK). RST is asynchronous and active-high. All outputs and state are registered.
- Reset values: state=IDLE, LED=0, STEP_IDX=0, BUSY=0, DONE=0, prescale count=0, duration count=0, direction=up.
- States:
  - IDLE: LED=0, BUSY=0.
  - RUN: counters advance, BUSY=1.
  - PAUSED: counters and LED frozen, BUSY=1.
- Input priority within a cycle: STOP > START > PAUSE.
- STOP in any state:
  - Next edge: IDLE, LED=0, STEP_IDX=0, counters cleared.
  - DONE is not asserted.
- START in any state:
  - Next edge: RUN, STEP_IDX=0, LED=PATTERNS step 0, counters cleared, direction=up.
  - MODE is latched at this edge and ignored afterwards.
- PAUSE:
  - RUN with PAUSE=1 → PAUSED at next edge; no counter increments on that edge.
  - PAUSED with PAUSE=0 → RUN; counting resumes from the frozen values.
  - PAUSE is ignored in IDLE.
- Tick generation:
  - The prescale counter counts 0..PRESCALE-1 in RUN only.
  - A tick occurs on the cycle it equals PRESCALE-1; the counter then wraps to 0.
- Step advance:
  - On a tick, when the duration count equals max(DURATIONS[k],1)-1, the step ends and the duration count clears; otherwise it increments.
  - Step k is therefore visible on LED for exactly PRESCALE*max(D_k,1) cycles.
- At a step end:
  - Loop: k=NUM_STEPS-1 wraps to 0.
  - One-shot: at k=NUM_STEPS-1, next edge is IDLE, LED=0, STEP_IDX=0, DONE=1 for one cycle; otherwise k+1.
  - Ping-pong: direction reverses at 0 and at NUM_STEPS-1; endpoints are not repeated (0,1,..,N-1,N-2,..,1,0,1,...).
- LED and STEP_IDX update on the same edge as the step change. Latency from the START edge to step-0 pattern on LED is 1 cycle.
- RST mid-sequence returns to reset values immediately, asynchronously; no DONE is generated.
- Widths: counters are sized from clog2 of PRESCALE and 2^DUR_W; no overflow occurs beyond these bounds.

Test Plan:
Use NUM_LEDS=4, NUM_STEPS=4, PRESCALE=2, DURATIONS={3,1,2,1}, PATTERNS={8,4,2,1} for all scenarios.
- Reset: assert RST asynchronously mid-cycle → LED=0, BUSY=0, DONE=0, STEP_IDX=0 with no clock edge needed.
- One-shot: START with MODE=1 → LED=1 for 2 cycles, 2 for 4, 4 for 2, 8 for 6. Then LED=0, DONE high for exactly 1 cycle 14 cycles after START, BUSY falls on the same edge.
- Loop: MODE=0, run 30 cycles → LED sequence 1,2,4,8,1,2,... with step lengths 2,4,2,6; DONE never asserted.
- Ping-pong: MODE=2 → STEP_IDX sequence 0,1,2,3,2,1,0,1; step 3 is held 6 cycles once per turn, not repeated.
- Pause: PAUSE high for 5 cycles during step 1 → LED stays 2 for 4+5 cycles total. Subsequent timing is shifted by exactly 5 cycles.
- Priority: START and STOP in the same cycle during RUN → IDLE, LED=0. START alone during step 2 → LED=1, STEP_IDX=0 next edge with counters restarted.
